leg_intc: RTL and testbench
===========================

# leg_intc

Parametrised interrupt controller for the LEG pipelined core. It collects up to NSRC asynchronous interrupt sources and synchronises them. Each source is latched as edge- or level-sensitive and masked, then steered to one of two core inputs, IRQ or FIQ, with fixed lowest-index priority. Software programs it through a word-addressed register port on the core's data-memory side and reads back the winning source ID from that port.

## Interface
Parameters:
- NSRC, 8, number of interrupt sources (legal range 1..32)
- IDW, $clog2(NSRC) (minimum 1), width of the source-ID field

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- src  input  NSRC  raw interrupt lines, asynchronous to clk, active-high
- addr  input  3  register word select (byte address bits [4:2])
- wdata  input  32  write data
- we  input  1  register write strobe, one-cycle pulse
- re  input  1  register read strobe, one-cycle pulse
- rdata  output  32  read data, registered
- irq  output  1  to core IRQ, registered
- fiq  output  1  to core FIQ, registered

## Operation
- Each src bit passes through a 2-flop synchroniser, giving s. Edge detection compares s against a delayed copy, sd.
- pending[i] update rule:
  - Edge mode (EDGE[i]=1): set on s&~sd; cleared by a CLEAR write with bit i = 1.
  - Level mode (EDGE[i]=0): pending[i] <= s[i]; CLEAR has no effect.
- Edge set and CLEAR in the same cycle: set wins, pending stays 1.
- Routing:
  - act = pending & ENABLE
  - fiq_req = |(act & FIQSEL)
  - irq_req = |(act & ~FIQSEL)
- Priority: the lowest set index of each request vector wins; the result is FIQID or IRQID.
- Register map (addr):
  - 0 RAW (RO): pending
  - 1 ENABLE (RW)
  - 2 FIQSEL (RW)
  - 3 EDGE (RW)
  - 4 CLEAR (WO, write-1-to-clear)
  - 5 IRQID (RO): {valid at bit 31, zeros, ID at [IDW-1:0]}
  - 6 FIQID (RO): same format as IRQID
  - 7 reserved: reads 0, writes ignored
- Width rules:
  - Register bits at or above NSRC read 0 and ignore writes.
  - Writes to RO registers are ignored.
  - CLEAR reads as 0.
- we and re asserted together: the write takes effect at the edge, and the read returns pre-write contents.
- Changing EDGE does not clear pending. Pending state is recomputed under the new mode from the next edge.

## Timing
- Reset (reset low, asynchronous): all of the following are 0:
  - synchronisers, sd, pending, ENABLE, FIQSEL, EDGE
  - rdata, irq, fiq
- Source latency: src rising with setup before edge N gives:
  - s=1 after N+1
  - pending=1 after N+2
  - irq/fiq=1 after N+3
- Deassertion: removal of the cause (CLEAR write, ENABLE write, or level drop) is reflected on irq/fiq one edge after pending or the register changes.
- Read latency: rdata is valid the cycle after re and holds its value until the next re.
- Write latency: register updates at the edge where we is sampled.
- Reset asserted mid-operation: outputs drop immediately (asynchronous). After release, no stale edge is detected, because sd resets to 0 together with s.
- Source held high through reset release: an edge is detected about 2 cycles later. This is intended behaviour.

## Structure
- Package leg_intc_pkg:
  - register offset constants (RAW..FIQID)
  - ID_VALID_BIT = 31
  - function for lowest-set-bit index over 32 bits
- Sub-module leg_sync2: parametrised-width 2-flop synchroniser with asynchronous active-low reset.

## Test plan
- Reset: hold reset low, toggle all src. Required: rdata, irq, fiq = 0. Required after release: RAW=0 and ENABLE=0 while src is held 0.
- Edge latch/clear:
  - Setup: NSRC=8, EDGE=0xFF, ENABLE=0x08. Pulse src[3] for 1 cycle.
  - Required: irq=1 exactly 3 edges after the sampled pulse; IRQID=0x8000_0003.
  - Write CLEAR=0x08. Required: irq=0 one edge later.
- Priority/steering:
  - Setup: ENABLE=0x24, FIQSEL=0x20. Hold src[2] and src[5] high (level mode).
  - Required: irq=1, fiq=1, IRQID=0x8000_0002, FIQID=0x8000_0005.
  - Drop src[5]. Required: fiq=0 four edges later.
- Set/clear collision: in edge mode, make the src[0] rising edge and a CLEAR=0x01 write land in the same cycle. Required: RAW[0]=1 afterwards.
- Width masking: NSRC=4. Write ENABLE=0xFFFF_FFFF. Required: read returns 0x0000_000F; addr 7 reads 0.
- Mid-operation reset: with irq=1, pulse reset low for 1 cycle while src stays high in edge mode. Required: irq=0 immediately; irq=1 again after about 3 edges.

Source files
------------

// File: rtl/leg_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : leg_intc_pkg
// Purpose  : Register offsets and priority helper for the LEG interrupt controller
// Revision : 1.0
// ============================================================================
package leg_intc_pkg;

    localparam logic [2:0] c_RAW    = 3'd0;
    localparam logic [2:0] c_ENABLE = 3'd1;
    localparam logic [2:0] c_FIQSEL = 3'd2;
    localparam logic [2:0] c_EDGE   = 3'd3;
    localparam logic [2:0] c_CLEAR  = 3'd4;
    localparam logic [2:0] c_IRQID  = 3'd5;
    localparam logic [2:0] c_FIQID  = 3'd6;

    localparam int c_ID_VALID_BIT = 31;

    // Index of the lowest set bit; returns 0 when no bit is set.
    function automatic logic [4:0] lowestSet(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leg_sync2.sv
`default_nettype none
// ============================================================================
// Module   : leg_sync2
// Purpose  : Parametrised-width two-flop synchroniser, async active-low reset
// Revision : 1.0
// ============================================================================
module leg_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/leg_intc.sv
`default_nettype none
// ============================================================================
// Module   : leg_intc
// Purpose  : Interrupt controller: sync, edge/level latch, mask, IRQ/FIQ steer
// Revision : 1.0
// ============================================================================
module leg_intc #(
    parameter int NSRC = 8,
    parameter int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    input  logic            we,
    input  logic            re,
    output logic [31:0]     rdata,
    output logic            irq,
    output logic            fiq
);
    import leg_intc_pkg::*;

    logic [NSRC-1:0] w_s;
    logic [NSRC-1:0] r_sd;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_enable;
    logic [NSRC-1:0] r_fiqSel;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] w_clear;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pendingNext;
    logic [NSRC-1:0] w_irqVec;
    logic [NSRC-1:0] w_fiqVec;
    logic [4:0]      w_irqIdx;
    logic [4:0]      w_fiqIdx;
    logic [31:0]     w_irqIdWord;
    logic [31:0]     w_fiqIdWord;
    logic [31:0]     w_readMux;
    logic [31:0]     r_rdata;
    logic            r_irq;
    logic            r_fiq;

    leg_sync2 #(.WIDTH(NSRC)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (src),
        .q     (w_s)
    );

    assign w_clear = (we && (addr == c_CLEAR)) ? wdata[NSRC-1:0] : '0;
    assign w_rise  = w_s & ~r_sd;

    // Edge bits: a new rising edge beats a simultaneous clear. Level bits follow s.
    assign w_pendingNext = (r_edge & (w_rise | (r_pending & ~w_clear))) | (~r_edge & w_s);

    assign w_irqVec = r_pending & r_enable & ~r_fiqSel;
    assign w_fiqVec = r_pending & r_enable & r_fiqSel;
    assign w_irqIdx = lowestSet(32'(w_irqVec));
    assign w_fiqIdx = lowestSet(32'(w_fiqVec));

    always_comb begin
        w_irqIdWord                 = '0;
        w_irqIdWord[c_ID_VALID_BIT] = |w_irqVec;
        w_irqIdWord[IDW-1:0]        = w_irqIdx[IDW-1:0];
        w_fiqIdWord                 = '0;
        w_fiqIdWord[c_ID_VALID_BIT] = |w_fiqVec;
        w_fiqIdWord[IDW-1:0]        = w_fiqIdx[IDW-1:0];
    end

    always_comb begin
        w_readMux = '0;
        case (addr)
            c_RAW:    w_readMux = 32'(r_pending);
            c_ENABLE: w_readMux = 32'(r_enable);
            c_FIQSEL: w_readMux = 32'(r_fiqSel);
            c_EDGE:   w_readMux = 32'(r_edge);
            c_IRQID:  w_readMux = w_irqIdWord;
            c_FIQID:  w_readMux = w_fiqIdWord;
            default:  w_readMux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sd      <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_fiqSel  <= '0;
            r_edge    <= '0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
            r_fiq     <= 1'b0;
        end else begin
            r_sd      <= w_s;
            r_pending <= w_pendingNext;
            r_irq     <= |w_irqVec;
            r_fiq     <= |w_fiqVec;
            if (re) r_rdata <= w_readMux;
            if (we) begin
                case (addr)
                    c_ENABLE: r_enable <= wdata[NSRC-1:0];
                    c_FIQSEL: r_fiqSel <= wdata[NSRC-1:0];
                    c_EDGE:   r_edge   <= wdata[NSRC-1:0];
                    default:  ;
                endcase
            end
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;
    assign fiq   = r_fiq;

    generate
        if (NSRC < 32) begin : g_unusedWdata
            logic w_unusedWdata;
            assign w_unusedWdata = ^wdata[31:NSRC];
        end
        if (IDW < 5) begin : g_unusedIdx
            logic w_unusedIdx;
            assign w_unusedIdx = ^{w_irqIdx[4:IDW], w_fiqIdx[4:IDW]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_leg_intc.sv
`default_nettype none
// ============================================================================
// Module   : tb_leg_intc
// Purpose  : Self-checking bench for leg_intc (NSRC=8 and NSRC=4 instances)
// Revision : 1.0
// ============================================================================
module tb_leg_intc;
    import leg_intc_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  src;
    logic [3:0]  src4;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        we, re, we4, re4;
    logic [31:0] rdata, rdata4;
    logic        irq, fiq, irq4, fiq4;

    int nTests = 0;
    int nFail  = 0;

    logic [31:0] expQ[$];
    string       nameQ[$];

    typedef struct {
        logic        doWr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[8];

    leg_intc #(.NSRC(8)) dut (
        .clk(clk), .reset(reset), .src(src), .addr(addr), .wdata(wdata),
        .we(we), .re(re), .rdata(rdata), .irq(irq), .fiq(fiq)
    );

    leg_intc #(.NSRC(4)) dut4 (
        .clk(clk), .reset(reset), .src(src4), .addr(addr), .wdata(wdata),
        .we(we4), .re(re4), .rdata(rdata4), .irq(irq4), .fiq(fiq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic wr(input bit d4, input logic [2:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        if (d4) we4 = 1'b1; else we = 1'b1;
        @(negedge clk);
        we  = 1'b0;
        we4 = 1'b0;
    endtask

    task automatic rd(input bit d4, input logic [2:0] a, input logic [31:0] e, input string nm);
        logic [31:0] ex;
        string       n;
        addr = a;
        if (d4) re4 = 1'b1; else re = 1'b1;
        expQ.push_back(e);
        nameQ.push_back(nm);
        @(negedge clk);
        re  = 1'b0;
        re4 = 1'b0;
        ex = expQ.pop_front();
        n  = nameQ.pop_front();
        check(n, d4 ? rdata4 : rdata, ex);
    endtask

    task automatic doReset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; src = '0; src4 = '0; addr = '0; wdata = '0;
        we = 1'b0; re = 1'b0; we4 = 1'b0; re4 = 1'b0;

        tbl[0] = '{1'b1, c_ENABLE, 32'hFFFF_FF5A, 32'h0000_005A, "tbl_enable"};
        tbl[1] = '{1'b1, c_FIQSEL, 32'h1234_56C3, 32'h0000_00C3, "tbl_fiqsel"};
        tbl[2] = '{1'b1, c_EDGE,   32'hFFFF_FF0F, 32'h0000_000F, "tbl_edge"};
        tbl[3] = '{1'b1, c_CLEAR,  32'hFFFF_FFFF, 32'h0000_0000, "tbl_clear_rd0"};
        tbl[4] = '{1'b1, c_RAW,    32'hFFFF_FFFF, 32'h0000_0000, "tbl_raw_ro"};
        tbl[5] = '{1'b1, 3'd7,     32'hFFFF_FFFF, 32'h0000_0000, "tbl_reserved"};
        tbl[6] = '{1'b1, c_IRQID,  32'hFFFF_FFFF, 32'h0000_0000, "tbl_irqid_idle"};
        tbl[7] = '{1'b0, c_ENABLE, 32'h0,         32'h0000_005A, "tbl_enable_hold"};

        // Reset held while sources toggle
        repeat (2) @(negedge clk);
        src = 8'hFF; src4 = 4'hF;
        @(negedge clk);
        src = 8'h00; src4 = 4'h0;
        @(negedge clk);
        src = 8'hFF;
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_fiq", 32'(fiq), 32'h0);
        src = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rd(0, c_RAW, 32'h0, "rst_raw");
        rd(0, c_ENABLE, 32'h0, "rst_enable");

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].doWr) wr(0, tbl[i].addr, tbl[i].wdata);
            rd(0, tbl[i].addr, tbl[i].exp, tbl[i].name);
        end

        // Edge latch, exact latency and clear
        doReset();
        wr(0, c_EDGE, 32'hFF);
        wr(0, c_ENABLE, 32'h08);
        src[3] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("edge_lat_early", 32'(irq), 32'h0);
        @(negedge clk);
        check("edge_lat", 32'(irq), 32'h1);
        rd(0, c_IRQID, 32'h8000_0003, "edge_irqid");
        wr(0, c_CLEAR, 32'h08);
        check("clr_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("clr_drop", 32'(irq), 32'h0);

        // Priority and steering, level mode
        doReset();
        wr(0, c_ENABLE, 32'h24);
        wr(0, c_FIQSEL, 32'h20);
        src = 8'h24;
        repeat (4) @(negedge clk);
        check("pri_irq", 32'(irq), 32'h1);
        check("pri_fiq", 32'(fiq), 32'h1);
        rd(0, c_IRQID, 32'h8000_0002, "pri_irqid");
        rd(0, c_FIQID, 32'h8000_0005, "pri_fiqid");
        src[5] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("lvl_drop_early", 32'(fiq), 32'h1);
        @(negedge clk);
        check("lvl_drop", 32'(fiq), 32'h0);
        check("lvl_irq_stays", 32'(irq), 32'h1);
        wr(0, c_CLEAR, 32'h04);
        rd(0, c_RAW, 32'h04, "lvl_clear_noeffect");
        // Simultaneous write and read returns pre-write contents
        addr = c_ENABLE; wdata = 32'h01; we = 1'b1; re = 1'b1;
        expQ.push_back(32'h24);
        nameQ.push_back("rdwr_old");
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        begin
            logic [31:0] ex;
            string       n;
            ex = expQ.pop_front();
            n  = nameQ.pop_front();
            check(n, rdata, ex);
        end
        rd(0, c_ENABLE, 32'h01, "rdwr_new");
        check("enable_deassert", 32'(irq), 32'h0);
        src = 8'h00;

        // Edge set colliding with clear
        doReset();
        wr(0, c_EDGE, 32'h01);
        wr(0, c_ENABLE, 32'h01);
        src[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr = c_CLEAR; wdata = 32'h01; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        rd(0, c_RAW, 32'h01, "collide_set_wins");
        wr(0, c_CLEAR, 32'h01);
        rd(0, c_RAW, 32'h00, "clear_no_edge");
        src = 8'h00;

        // Width masking on the 4-source instance
        wr(1, c_ENABLE, 32'hFFFF_FFFF);
        rd(1, c_ENABLE, 32'h0000_000F, "w4_enable");
        wr(1, 3'd7, 32'hFFFF_FFFF);
        rd(1, 3'd7, 32'h0, "w4_reserved");

        // Reset asserted mid-operation with a source held high
        doReset();
        wr(0, c_EDGE, 32'h08);
        wr(0, c_ENABLE, 32'h08);
        src[3] = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_irq_before", 32'(irq), 32'h1);
        #2 reset = 1'b0;
        #1 check("mid_irq_async", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        addr = c_EDGE; wdata = 32'h08; we = 1'b1;
        @(negedge clk);
        addr = c_ENABLE; wdata = 32'h08;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        check("mid_irq_early", 32'(irq), 32'h0);
        @(negedge clk);
        check("mid_irq_again", 32'(irq), 32'h1);
        src = 8'h00;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
